shift_stage: RTL



---
 rtl/shift_stage.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/shift_stage.sv
// rtl/shift_stage.sv - two-stage ARM operand-2 barrel shifter with valid/ready handshake
// S1 holds the operand plus a decoded shift control word; S2 holds the shifted result and carry.
module shift_stage (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        Flush,
  input  logic        InValid,
  output logic        InReady,
  input  logic [31:0] ShIn,
  input  logic [1:0]  Sh,
  input  logic [7:0]  ShAmt,
  input  logic        ShReg,
  input  logic        CarryIn,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [31:0] ShOut,
  output logic        ShCarry
);

  typedef enum logic [2:0] {
    K_PASS, K_LSL, K_LSR, K_ASR, K_ROR, K_ZERO, K_SIGN, K_RRX
  } kind_e;

  typedef enum logic [2:0] {
    C_IN, C_SHIFT, C_B31, C_B0, C_ZERO
  } csel_e;

  logic        v1_q, v2_q;
  logic [31:0] d1_q;
  logic        cin1_q;
  kind_e       kind_q, kind_d;
  logic [4:0]  dist_q, dist_d;
  csel_e       csel_q, csel_d;
  logic [31:0] out_q, out_d;
  logic        carry_q, carry_d;

  logic        adv1, adv2;
  logic        amt_ge32, amt_eq32;
  logic [5:0]  lidx;
  logic        shift_carry;

  assign adv2     = !v2_q || OutReady;
  assign adv1     = !v1_q || adv2;
  assign InReady  = adv1;
  assign OutValid = v2_q;
  assign ShOut    = out_q;
  assign ShCarry  = carry_q;

  assign amt_ge32 = |ShAmt[7:5];
  assign amt_eq32 = (ShAmt == 8'd32);

  // Immediate #0 encodings and out-of-range register amounts collapse into fixed kinds here,
  // so S2 only ever shifts by a distance of 1..31.
  always_comb begin
    kind_d = K_PASS;
    dist_d = ShAmt[4:0];
    csel_d = C_IN;
    if (!ShReg) begin
      unique case (Sh)
        2'b00: if (ShAmt[4:0] != 5'd0) begin kind_d = K_LSL; csel_d = C_SHIFT; end
        2'b01: if (ShAmt[4:0] == 5'd0) begin kind_d = K_ZERO; csel_d = C_B31; end
               else begin kind_d = K_LSR; csel_d = C_SHIFT; end
        2'b10: if (ShAmt[4:0] == 5'd0) begin kind_d = K_SIGN; csel_d = C_B31; end
               else begin kind_d = K_ASR; csel_d = C_SHIFT; end
        default: if (ShAmt[4:0] == 5'd0) begin kind_d = K_RRX; csel_d = C_B0; end
                 else begin kind_d = K_ROR; csel_d = C_SHIFT; end
      endcase
    end else if (ShAmt != 8'd0) begin
      unique case (Sh)
        2'b00: if (!amt_ge32) begin kind_d = K_LSL; csel_d = C_SHIFT; end
               else begin kind_d = K_ZERO; csel_d = amt_eq32 ? C_B0 : C_ZERO; end
        2'b01: if (!amt_ge32) begin kind_d = K_LSR; csel_d = C_SHIFT; end
               else begin kind_d = K_ZERO; csel_d = amt_eq32 ? C_B31 : C_ZERO; end
        2'b10: if (!amt_ge32) begin kind_d = K_ASR; csel_d = C_SHIFT; end
               else begin kind_d = K_SIGN; csel_d = C_B31; end
        default: if (ShAmt[4:0] == 5'd0) begin kind_d = K_PASS; csel_d = C_B31; end
                 else begin kind_d = K_ROR; csel_d = C_SHIFT; end
      endcase
    end
  end

  assign lidx        = 6'd32 - {1'b0, dist_q};
  assign shift_carry = (kind_q == K_LSL) ? d1_q[lidx[4:0]] : d1_q[dist_q - 5'd1];

  always_comb begin
    out_d = d1_q;
    unique case (kind_q)
      K_PASS:  out_d = d1_q;
      K_LSL:   out_d = d1_q << dist_q;
      K_LSR:   out_d = d1_q >> dist_q;
      K_ASR:   out_d = 32'($signed(d1_q) >>> dist_q);
      K_ROR:   out_d = (d1_q >> dist_q) | (d1_q << lidx);
      K_ZERO:  out_d = 32'd0;
      K_SIGN:  out_d = {32{d1_q[31]}};
      default: out_d = {cin1_q, d1_q[31:1]};
    endcase
    carry_d = 1'b0;
    unique case (csel_q)
      C_IN:    carry_d = cin1_q;
      C_SHIFT: carry_d = shift_carry;
      C_B31:   carry_d = d1_q[31];
      C_B0:    carry_d = d1_q[0];
      default: carry_d = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      d1_q    <= 32'd0;
      cin1_q  <= 1'b0;
      kind_q  <= K_PASS;
      dist_q  <= 5'd0;
      csel_q  <= C_IN;
      out_q   <= 32'd0;
      carry_q <= 1'b0;
    end else if (Flush) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      if (adv2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          out_q   <= out_d;
          carry_q <= carry_d;
        end
      end
      if (adv1) begin
        v1_q <= InValid;
        if (InValid) begin
          d1_q   <= ShIn;
          cin1_q <= CarryIn;
          kind_q <= kind_d;
          dist_q <= dist_d;
          csel_q <= csel_d;
        end
      end
    end
  end

endmodule
